// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: serialises {addr, data} frames to one of NUM_CS slaves
// on a shared SCLK/MOSI/MISO bus, one request at a time, with a one-cycle response pulse.
//
// state | meaning
// IDLE  | ready for a request; response pulse is issued on the first IDLE cycle
// SHIFT | 2N half-periods of SCLK, CS low (unless cs index is invalid)
// HOLD  | one half-period with SCLK/MOSI low, CS still low
// GAP   | GAP_HP half-periods with every CS high
module spi_reg_master #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int NUM_CS    = 2,
   parameter int CLK_DIV   = 4,
   parameter int GAP_HP    = 2,
   parameter bit RD_BIT_EN = 1'b1,
   localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              i_clk125,
   input  logic              i_srst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_rd,
   input  logic [CS_W-1:0]   i_req_cs,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_busy,
   output logic [NUM_CS-1:0] o_cs_n,
   output logic              o_sclk,
   output logic              o_mosi,
   input  logic              i_miso
);

   localparam int N      = ADDR_W + DATA_W;
   localparam int HP_MAX = (2 * N > GAP_HP) ? 2 * N : GAP_HP;
   localparam int HP_W   = $clog2(HP_MAX + 1);
   localparam int DIV_W  = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_TC        = DIV_W'(CLK_DIV - 1);
   localparam logic [HP_W-1:0]  HP_SHIFT_LAST = HP_W'(2 * N - 1);
   localparam logic [HP_W-1:0]  HP_DATA_FIRST = HP_W'(2 * ADDR_W);
   localparam logic [HP_W-1:0]  HP_GAP_LAST   = HP_W'(GAP_HP - 1);
   localparam logic [31:0]      NUM_CS_U      = NUM_CS;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t              r_state, w_state_nxt;
   logic [DIV_W-1:0]    r_div, w_div_nxt;
   logic [HP_W-1:0]     r_hp, w_hp_nxt;
   logic [N-1:0]        r_tx, w_tx_nxt;
   logic [DATA_W-1:0]   r_rx, w_rx_nxt;
   logic                r_rd, w_rd_nxt;
   logic                r_err, w_err_nxt;
   logic [NUM_CS-1:0]   r_cs_n, w_cs_n_nxt;
   logic                r_sclk, w_sclk_nxt;
   logic                r_mosi, w_mosi_nxt;
   logic                r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
   logic                r_rsp_err, w_rsp_err_nxt;
   logic                r_busy;
   logic                r_ready;

   logic                w_tick;
   logic                w_cs_ok;
   logic [NUM_CS-1:0]   w_sel_req;
   logic [ADDR_W-1:0]   w_addr_mod;
   logic [N-1:0]        w_tx_word;

   assign w_tick  = (r_div == DIV_TC);
   assign w_cs_ok = (32'(i_req_cs) < NUM_CS_U);

   // An out-of-range index keeps every CS high while the frame timing still runs.
   assign w_sel_req = w_cs_ok ? ~(NUM_CS'(1) << i_req_cs) : '1;

   always_comb begin
      w_addr_mod = i_req_addr;
      if (RD_BIT_EN) w_addr_mod[ADDR_W-1] = i_req_rd;
      w_tx_word = {w_addr_mod, (i_req_rd ? {DATA_W{1'b0}} : i_req_wdata)};
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_div_nxt       = r_div;
      w_hp_nxt        = r_hp;
      w_tx_nxt        = r_tx;
      w_rx_nxt        = r_rx;
      w_rd_nxt        = r_rd;
      w_err_nxt       = r_err;
      w_cs_n_nxt      = r_cs_n;
      w_sclk_nxt      = r_sclk;
      w_mosi_nxt      = r_mosi;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = 1'b0;

      if (r_state != S_IDLE) w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);

      case (r_state)
         S_IDLE: begin
            if (i_req_valid) begin
               w_state_nxt = S_SHIFT;
               w_div_nxt   = '0;
               w_hp_nxt    = '0;
               w_tx_nxt    = w_tx_word;
               w_rx_nxt    = '0;
               w_rd_nxt    = i_req_rd;
               w_err_nxt   = ~w_cs_ok;
               w_cs_n_nxt  = w_sel_req;
               w_sclk_nxt  = 1'b0;
               w_mosi_nxt  = w_tx_word[N-1];
            end
         end
         S_SHIFT: begin
            if (w_tick) begin
               // Odd half-periods are SCLK high; the last cycle of each one samples MISO.
               if (r_hp[0] && (r_hp >= HP_DATA_FIRST))
                  w_rx_nxt = (r_rx << 1) | DATA_W'(i_miso);
               if (r_hp == HP_SHIFT_LAST) begin
                  w_state_nxt = S_HOLD;
                  w_sclk_nxt  = 1'b0;
                  w_mosi_nxt  = 1'b0;
               end else begin
                  w_hp_nxt = r_hp + HP_W'(1);
                  if (!r_hp[0]) begin
                     w_sclk_nxt = 1'b1;
                  end else begin
                     w_sclk_nxt = 1'b0;
                     w_tx_nxt   = r_tx << 1;
                     w_mosi_nxt = r_tx[N-2];
                  end
               end
            end
         end
         S_HOLD: begin
            if (w_tick) begin
               w_state_nxt = S_GAP;
               w_hp_nxt    = '0;
               w_cs_n_nxt  = '1;
            end
         end
         S_GAP: begin
            if (w_tick) begin
               if (r_hp == HP_GAP_LAST) begin
                  w_state_nxt     = S_IDLE;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_err_nxt   = r_err;
                  w_rsp_rdata_nxt = r_rd ? r_rx : '0;
               end else begin
                  w_hp_nxt = r_hp + HP_W'(1);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk125) begin
      if (i_srst) begin
         r_state     <= S_IDLE;
         r_div       <= '0;
         r_hp        <= '0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_rd        <= 1'b0;
         r_err       <= 1'b0;
         r_cs_n      <= '1;
         r_sclk      <= 1'b0;
         r_mosi      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_div       <= w_div_nxt;
         r_hp        <= w_hp_nxt;
         r_tx        <= w_tx_nxt;
         r_rx        <= w_rx_nxt;
         r_rd        <= w_rd_nxt;
         r_err       <= w_err_nxt;
         r_cs_n      <= w_cs_n_nxt;
         r_sclk      <= w_sclk_nxt;
         r_mosi      <= w_mosi_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_ready     <= (w_state_nxt == S_IDLE);
      end
   end

   assign o_req_ready = r_ready;
   assign o_busy      = r_busy;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;
   assign o_cs_n      = r_cs_n;
   assign o_sclk      = r_sclk;
   assign o_mosi      = r_mosi;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: an 8+8-bit instance with three chip selects and a 7+16-bit
// instance at CLK_DIV=2 without the read bit; responses are checked against a scoreboard.
module tb_spi_reg_master;

   logic clk = 1'b0;
   always #4 clk = ~clk;
   logic srst;

   logic       v1, rd1, miso1, rdy1, rspv1, err1, busy1, sclk1, mosi1;
   logic [1:0] cs1;
   logic [7:0] addr1, wd1, rdata1;
   logic [2:0] csn1;

   logic        v2, rd2, cs2, miso2, rdy2, rspv2, err2, busy2, sclk2, mosi2;
   logic [6:0]  addr2;
   logic [15:0] wd2, rdata2;
   logic [1:0]  csn2;

   spi_reg_master #(.ADDR_W(8), .DATA_W(8), .NUM_CS(3), .CLK_DIV(4), .GAP_HP(2), .RD_BIT_EN(1'b1)) u_dut1 (
      .i_clk125(clk), .i_srst(srst), .i_req_valid(v1), .o_req_ready(rdy1), .i_req_rd(rd1),
      .i_req_cs(cs1), .i_req_addr(addr1), .i_req_wdata(wd1), .o_rsp_valid(rspv1),
      .o_rsp_rdata(rdata1), .o_rsp_err(err1), .o_busy(busy1), .o_cs_n(csn1),
      .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(miso1));

   spi_reg_master #(.ADDR_W(7), .DATA_W(16), .NUM_CS(2), .CLK_DIV(2), .GAP_HP(2), .RD_BIT_EN(1'b0)) u_dut2 (
      .i_clk125(clk), .i_srst(srst), .i_req_valid(v2), .o_req_ready(rdy2), .i_req_rd(rd2),
      .i_req_cs(cs2), .i_req_addr(addr2), .i_req_wdata(wd2), .o_rsp_valid(rspv2),
      .o_rsp_rdata(rdata2), .o_rsp_err(err2), .o_busy(busy2), .o_cs_n(csn2),
      .o_sclk(sclk2), .o_mosi(mosi2), .i_miso(miso2));

   typedef struct {
      logic [31:0] mosi;
      logic [15:0] rdata;
      logic        err;
      logic [2:0]  cs_and;
      int          cs_lo;
   } exp_t;

   exp_t sb1[$];
   exp_t sb2[$];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor state (written only by the negedge monitor, except sw1/sw2 set by stimulus)
   int          cyc = 0;
   int          acc1 = 0, edges1 = 0, cslo1 = 0, t_rsp1 = 0, n_rsp1 = 0, multi_lo = 0;
   int          t_last_lo = 0, t_first_lo = 0, prev_last = 0;
   int          acc2 = 0, edges2 = 0, n_rsp2 = 0;
   logic [31:0] msh1 = '0, msh2 = '0;
   logic [2:0]  csand1 = '1;
   logic        first_seen = 1'b0, psclk1 = 1'b0, psclk2 = 1'b0;
   logic [7:0]  sw1 = '0;
   logic [15:0] sw2 = '0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (srst) begin
         psclk1 = 1'b0;
         psclk2 = 1'b0;
         miso1  = 1'b0;
         miso2  = 1'b0;
      end else begin
         if (rspv1) begin
            n_rsp1++;
            t_rsp1 = cyc;
            chk("rsp1_expected", 32'(sb1.size() != 0), 32'd1);
            if (sb1.size() != 0) begin
               e = sb1.pop_front();
               chk("rsp1_rdata", 32'(rdata1), 32'(e.rdata));
               chk("rsp1_err", 32'(err1), 32'(e.err));
               chk("rsp1_mosi_word", msh1, e.mosi);
               chk("rsp1_sclk_edges", 32'(edges1), 32'd16);
               chk("rsp1_cs_and", 32'(csand1), 32'(e.cs_and));
               chk("rsp1_cs_lo_cycles", 32'(cslo1), 32'(e.cs_lo));
               chk("rsp1_latency", 32'(cyc - acc1), 32'd141);
            end
         end
         if (v1 && rdy1) begin
            acc1 = cyc; edges1 = 0; msh1 = '0; cslo1 = 0; csand1 = '1;
            prev_last = t_last_lo; first_seen = 1'b0;
         end
         if (sclk1 && !psclk1) begin
            msh1 = {msh1[30:0], mosi1};
            edges1++;
         end
         if (csn1 != 3'b111) begin
            cslo1++;
            csand1 = csand1 & csn1;
            t_last_lo = cyc;
            if (!first_seen) begin
               first_seen = 1'b1;
               t_first_lo = cyc;
            end
            if ($countones(~csn1) != 1) multi_lo++;
         end
         if (!sclk1) miso1 = (edges1 >= 8 && edges1 < 16) ? sw1[3'(15 - edges1)] : 1'b0;
         psclk1 = sclk1;

         if (rspv2) begin
            n_rsp2++;
            chk("rsp2_expected", 32'(sb2.size() != 0), 32'd1);
            if (sb2.size() != 0) begin
               e = sb2.pop_front();
               chk("rsp2_rdata", 32'(rdata2), 32'(e.rdata));
               chk("rsp2_err", 32'(err2), 32'(e.err));
               chk("rsp2_mosi_word", msh2, e.mosi);
               chk("rsp2_sclk_edges", 32'(edges2), 32'd23);
               chk("rsp2_latency", 32'(cyc - acc2), 32'd99);
            end
         end
         if (v2 && rdy2) begin
            acc2 = cyc; edges2 = 0; msh2 = '0;
         end
         if (sclk2 && !psclk2) begin
            msh2 = {msh2[30:0], mosi2};
            edges2++;
         end
         if (!sclk2) miso2 = (edges2 >= 7 && edges2 < 23) ? sw2[4'(22 - edges2)] : 1'b0;
         psclk2 = sclk2;
      end
   end

   function automatic exp_t exp1(input logic rd, input logic [1:0] cs, input logic [7:0] addr,
                                 input logic [7:0] wd, input logic [7:0] sw);
      exp_t e;
      e.mosi   = {16'h0000, rd, addr[6:0], (rd ? 8'h00 : wd)};
      e.rdata  = rd ? {8'h00, sw} : 16'h0000;
      e.err    = (cs == 2'd3);
      e.cs_and = e.err ? 3'b111 : ~(3'b001 << cs);
      e.cs_lo  = e.err ? 0 : 132;
      return e;
   endfunction

   task automatic wait_acc1();
      bit got = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rdy1) begin got = 1'b1; break; end
      end
      chk("acc1_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_acc2();
      bit got = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rdy2) begin got = 1'b1; break; end
      end
      chk("acc2_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic req1(input logic rd, input logic [1:0] cs, input logic [7:0] addr,
                       input logic [7:0] wd, input logic [7:0] sw);
      sb1.push_back(exp1(rd, cs, addr, wd, sw));
      sw1 = sw; rd1 = rd; cs1 = cs; addr1 = addr; wd1 = wd; v1 = 1'b1;
      wait_acc1();
      v1 = 1'b0;
   endtask

   task automatic req2(input logic rd, input logic cs, input logic [6:0] addr,
                       input logic [15:0] wd, input logic [15:0] sw);
      exp_t e;
      e.mosi = {9'h000, addr, (rd ? 16'h0000 : wd)};
      e.rdata = rd ? sw : 16'h0000;
      e.err = 1'b0; e.cs_and = 3'b111; e.cs_lo = 0;
      sb2.push_back(e);
      sw2 = sw; rd2 = rd; cs2 = cs; addr2 = addr; wd2 = wd; v2 = 1'b1;
      wait_acc2();
      v2 = 1'b0;
   endtask

   task automatic wait_done1();
      for (int i = 0; i < 2000; i++) begin
         if (sb1.size() == 0) break;
         @(posedge clk);
      end
      chk("done1_timeout", 32'(sb1.size()), 32'd0);
      #1;
   endtask

   task automatic wait_done2();
      for (int i = 0; i < 2000; i++) begin
         if (sb2.size() == 0) break;
         @(posedge clk);
      end
      chk("done2_timeout", 32'(sb2.size()), 32'd0);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      bit got;
      srst = 1'b1;
      v1 = 1'b0; rd1 = 1'b0; cs1 = '0; addr1 = '0; wd1 = '0;
      v2 = 1'b0; rd2 = 1'b0; cs2 = 1'b0; addr2 = '0; wd2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", 32'(csn1), 32'h7);
      chk("rst_sclk", 32'(sclk1), 32'd0);
      chk("rst_mosi", 32'(mosi1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_rsp_valid", 32'(rspv1), 32'd0);
      chk("rst_rsp_err", 32'(err1), 32'd0);
      chk("rst_rdata", 32'(rdata1), 32'd0);
      chk("rst_ready", 32'(rdy1), 32'd1);
      chk("rst2_state", {26'h0, rdy2, busy2, csn2, sclk2, mosi2}, {26'h0, 6'b101100});
      srst = 1'b0;
      @(posedge clk); #1;

      // Write cs0 0x02/0x1A, then read cs1 0x05 with slave data 0xA5
      req1(1'b0, 2'd0, 8'h02, 8'h1A, 8'h00);
      wait_done1();
      req1(1'b1, 2'd1, 8'h05, 8'h00, 8'hA5);
      wait_done1();
      repeat (5) @(posedge clk);
      #1;
      chk("rdata_hold", 32'(rdata1), 32'hA5);

      // Back-to-back writes with valid held high
      sb1.push_back(exp1(1'b0, 2'd0, 8'h11, 8'h3C, 8'h00));
      sb1.push_back(exp1(1'b0, 2'd1, 8'h7F, 8'hC4, 8'h00));
      rd1 = 1'b0; cs1 = 2'd0; addr1 = 8'h11; wd1 = 8'h3C; v1 = 1'b1;
      wait_acc1();
      cs1 = 2'd1; addr1 = 8'h7F; wd1 = 8'hC4;
      wait_acc1();
      v1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_accept_on_rsp", 32'(acc1), 32'(t_rsp1));
      chk("b2b_cs_high_gap", 32'(t_first_lo - prev_last - 1), 32'd9);
      wait_done1();

      // Out-of-range chip select
      req1(1'b0, 2'd3, 8'h44, 8'h99, 8'h00);
      wait_done1();

      // Reset mid-frame at the 7th SCLK rising edge
      req1(1'b0, 2'd0, 8'h33, 8'h77, 8'h00);
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (edges1 >= 7) begin got = 1'b1; break; end
      end
      chk("edge7_timeout", 32'(got), 32'd1);
      srst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_cs_n", 32'(csn1), 32'h7);
      chk("midrst_sclk", 32'(sclk1), 32'd0);
      chk("midrst_busy", 32'(busy1), 32'd0);
      chk("midrst_ready", 32'(rdy1), 32'd1);
      chk("midrst_rsp_valid", 32'(rspv1), 32'd0);
      srst = 1'b0;
      sb1.delete();
      snap = n_rsp1;
      repeat (200) @(posedge clk);
      #1;
      chk("no_rsp_after_reset", 32'(n_rsp1), 32'(snap));
      req1(1'b0, 2'd1, 8'h3C, 8'h5A, 8'h00);
      wait_done1();

      // Second instance: 7-bit address sent unmodified, 16-bit data, CLK_DIV=2
      req2(1'b0, 1'b1, 7'h55, 16'hC3A5, 16'h0000);
      wait_done2();
      req2(1'b1, 1'b0, 7'h2A, 16'hFFFF, 16'h9F31);
      wait_done2();

      repeat (4) @(posedge clk);
      #1;
      chk("multi_cs_low", 32'(multi_lo), 32'd0);
      chk("rsp1_count", 32'(n_rsp1), 32'd6);
      chk("rsp2_count", 32'(n_rsp2), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
